maxpool_layer: RTL and testbench

Downstream consumer of a convolution layer's output memory. After the convolution layer reports its result valid, this block reads each channel's OUTPUT_DIM x OUTPUT_DIM feature map through the convolution layer's read-index port. It computes non-overlapping POOL_DIM x POOL_DIM max pooling on 64-bit IEEE-754 double values. Each pooled result is written into the next layer's activation memory through an entry/y/x write port.

---
 rtl/maxpool_layer.sv | 160 ++++++++++++++++
 tb/tb_maxpool_layer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_layer.sv
// Max-pooling stage: reads an upstream conv output map tap by tap and writes each
// POOL_DIM x POOL_DIM window maximum (IEEE-754 doubles, bitwise compare) downstream.
module maxpool_layer #(
  parameter string NAME         = "MAXPOOL_LAYER_DEFAULT_NAME",
  parameter int    NUM_CHANNELS = 1,
  parameter int    INPUT_DIM    = 4,
  parameter int    POOL_DIM     = 2,
  parameter int    DATA_SIZE    = 64,
  parameter int    POOL_OUT_DIM = INPUT_DIM / POOL_DIM,
  parameter int    DEBUG        = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [2:0][15:0]     rd_index,
  input  logic [DATA_SIZE-1:0] rd_data,
  output logic                 wr_en,
  output logic [2:0][15:0]     wr_index,
  output logic [DATA_SIZE-1:0] wr_data,
  output logic                 output_valid,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CMP,
    WRITE,
    DONE
  } state_t;

  localparam logic [15:0] PoolLast = 16'(POOL_DIM - 1);
  localparam logic [15:0] OutLast  = 16'(POOL_OUT_DIM - 1);
  localparam logic [15:0] ChLast   = 16'(NUM_CHANNELS - 1);

  state_t                 state_q, state_d;
  logic [15:0]            ch_q, ch_d;
  logic [15:0]            oy_q, oy_d;
  logic [15:0]            ox_q, ox_d;
  logic [15:0]            ky_q, ky_d;
  logic [15:0]            kx_q, kx_d;
  logic [DATA_SIZE-1:0]   max_q, max_d;
  logic [2:0][15:0]       rd_index_q, rd_index_d;

  // Sign/magnitude ordering of doubles; any zero-vs-zero pair counts as a tie so the held value stays.
  function automatic logic takesNew(input logic [DATA_SIZE-1:0] held,
                                    input logic [DATA_SIZE-1:0] cand);
    logic                 heldNeg;
    logic                 candNeg;
    logic [DATA_SIZE-2:0] heldMag;
    logic [DATA_SIZE-2:0] candMag;
    heldNeg = held[DATA_SIZE-1];
    candNeg = cand[DATA_SIZE-1];
    heldMag = held[DATA_SIZE-2:0];
    candMag = cand[DATA_SIZE-2:0];
    if ((heldMag == '0) && (candMag == '0)) return 1'b0;
    if (heldNeg != candNeg) return heldNeg;
    if (!heldNeg) return candMag > heldMag;
    return candMag < heldMag;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      oy_q       <= '0;
      ox_q       <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      max_q      <= '0;
      rd_index_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      oy_q       <= oy_d;
      ox_q       <= ox_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      max_q      <= max_d;
      rd_index_q <= rd_index_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    oy_d       = oy_q;
    ox_d       = ox_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    max_d      = max_q;
    rd_index_d = rd_index_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          ch_d    = '0;
          oy_d    = '0;
          ox_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
          state_d = ISSUE;
        end
      end

      ISSUE: state_d = CMP;

      CMP: begin
        if (((ky_q == '0) && (kx_q == '0)) || takesNew(max_q, rd_data)) max_d = rd_data;
        state_d = ISSUE;
        if (kx_q == PoolLast) begin
          kx_d = '0;
          if (ky_q == PoolLast) begin
            ky_d    = '0;
            state_d = WRITE;
          end else begin
            ky_d = ky_q + 16'd1;
          end
        end else begin
          kx_d = kx_q + 16'd1;
        end
      end

      WRITE: begin
        state_d = ISSUE;
        if (ox_q == OutLast) begin
          ox_d = '0;
          if (oy_q == OutLast) begin
            oy_d = '0;
            if (ch_q == ChLast) begin
              ch_d    = '0;
              state_d = DONE;
            end else begin
              ch_d = ch_q + 16'd1;
            end
          end else begin
            oy_d = oy_q + 16'd1;
          end
        end else begin
          ox_d = ox_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // The address is launched on entry to ISSUE so a registered-read memory returns data during CMP.
    if (state_d == ISSUE) begin
      rd_index_d = {ch_d, 16'(oy_d * POOL_DIM + ky_d), 16'(ox_d * POOL_DIM + kx_d)};
    end
  end

  assign rd_index     = rd_index_q;
  assign wr_en        = (state_q == WRITE);
  assign wr_index     = wr_en ? {ch_q, oy_q, ox_q} : '0;
  assign wr_data      = wr_en ? max_q : '0;
  assign output_valid = (state_q == DONE);
  assign busy         = (state_q == ISSUE) || (state_q == CMP) || (state_q == WRITE);

endmodule

// File: tb/tb_maxpool_layer.sv
// Directed bench for maxpool_layer: three instances (default, 5x5 input, two channels)
// fed from registered-read memory models; every write is logged and compared.
module tb_maxpool_layer;

  typedef logic [2:0][15:0] idx_t;
  typedef struct packed {
    idx_t        idx;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic startA, startB, startC;
  idx_t rdIdxA, rdIdxB, rdIdxC, wrIdxA, wrIdxB, wrIdxC;
  logic [63:0] rdDataA, rdDataB, rdDataC, wrDataA, wrDataB, wrDataC;
  logic wrEnA, wrEnB, wrEnC, ovA, ovB, ovC, busyA, busyB, busyC;

  logic [63:0] memA [16];
  logic [63:0] memB [25];
  logic [63:0] memC [32];

  maxpool_layer #(.NUM_CHANNELS(1), .INPUT_DIM(4), .POOL_DIM(2)) dutA (
    .clk(clk), .rst_n(rst_n), .start(startA), .rd_index(rdIdxA), .rd_data(rdDataA),
    .wr_en(wrEnA), .wr_index(wrIdxA), .wr_data(wrDataA), .output_valid(ovA), .busy(busyA));

  maxpool_layer #(.NUM_CHANNELS(1), .INPUT_DIM(5), .POOL_DIM(2)) dutB (
    .clk(clk), .rst_n(rst_n), .start(startB), .rd_index(rdIdxB), .rd_data(rdDataB),
    .wr_en(wrEnB), .wr_index(wrIdxB), .wr_data(wrDataB), .output_valid(ovB), .busy(busyB));

  maxpool_layer #(.NUM_CHANNELS(2), .INPUT_DIM(4), .POOL_DIM(2)) dutC (
    .clk(clk), .rst_n(rst_n), .start(startC), .rd_index(rdIdxC), .rd_data(rdDataC),
    .wr_en(wrEnC), .wr_index(wrIdxC), .wr_data(wrDataC), .output_valid(ovC), .busy(busyC));

  // Upstream memories answer one cycle after the index is presented.
  always @(posedge clk) begin
    rdDataA <= memA[(int'(rdIdxA[1]) * 4 + int'(rdIdxA[0])) % 16];
    rdDataB <= memB[(int'(rdIdxB[1]) * 5 + int'(rdIdxB[0])) % 25];
    rdDataC <= memC[(int'(rdIdxC[2]) * 16 + int'(rdIdxC[1]) * 4 + int'(rdIdxC[0])) % 32];
  end

  wr_t wrLog[$];
  int  oobB = 0;

  // Only one instance runs at a time, so a single write log serves all three.
  always @(negedge clk) begin
    if (wrEnA) wrLog.push_back({wrIdxA, wrDataA});
    if (wrEnB) wrLog.push_back({wrIdxB, wrDataB});
    if (wrEnC) wrLog.push_back({wrIdxC, wrDataC});
    if (busyB && ((rdIdxB[1] > 16'd3) || (rdIdxB[0] > 16'd3))) oobB++;
  end

  int          checkCount = 0;
  int          errorCount = 0;
  idx_t        expIdx [8];
  logic [63:0] expData [8];
  logic        validAfterStart;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setExp(input int i, input int ch, input int y, input int x,
                        input logic [63:0] bits);
    expIdx[i]  = {16'(ch), 16'(y), 16'(x)};
    expData[i] = bits;
  endtask

  task automatic setStart(input int sel, input logic v);
    case (sel)
      0:       startA = v;
      1:       startB = v;
      default: startC = v;
    endcase
  endtask

  function automatic logic validOf(input int sel);
    case (sel)
      0:       return ovA;
      1:       return ovB;
      default: return ovC;
    endcase
  endfunction

  // Pulses start, optionally re-pulses it while busy, and measures cycles to output_valid.
  task automatic applyStimulus(input int sel, input bit pokeMid, output int latency);
    int n;
    int t0;
    @(negedge clk);
    setStart(sel, 1'b1);
    @(negedge clk);
    setStart(sel, 1'b0);
    t0 = cyc;
    validAfterStart = validOf(sel);
    n = 0;
    while (!validOf(sel) && (n < 400)) begin
      setStart(sel, pokeMid && (n == 8));
      @(negedge clk);
      n++;
    end
    setStart(sel, 1'b0);
    checkOutput("done timeout", 64'(n < 400), 64'd1);
    latency = cyc - t0;
  endtask

  task automatic verifyLog(input string tag, input int n);
    checkOutput($sformatf("%s count", tag), 64'(wrLog.size()), 64'(n));
    for (int i = 0; (i < n) && (i < wrLog.size()); i++) begin
      checkOutput($sformatf("%s idx%0d", tag, i), 64'(wrLog[i].idx), 64'(expIdx[i]));
      checkOutput($sformatf("%s data%0d", tag, i), wrLog[i].data, expData[i]);
    end
  endtask

  task automatic expectRamp();
    setExp(0, 0, 0, 0, $realtobits(6.0));
    setExp(1, 0, 0, 1, $realtobits(8.0));
    setExp(2, 0, 1, 0, $realtobits(14.0));
    setExp(3, 0, 1, 1, $realtobits(16.0));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " wr_en"}, 64'(wrEnA), 64'd0);
    checkOutput({tag, " busy"}, 64'(busyA), 64'd0);
    checkOutput({tag, " valid"}, 64'(ovA), 64'd0);
    checkOutput({tag, " rd_index"}, 64'(rdIdxA), 64'd0);
    checkOutput({tag, " wr_index"}, 64'(wrIdxA), 64'd0);
    checkOutput({tag, " wr_data"}, wrDataA, 64'd0);
  endtask

  initial begin
    int lat;
    int n;
    rst_n  = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
    for (int i = 0; i < 16; i++) begin
      memA[i]      = $realtobits(real'(i + 1));
      memC[i]      = $realtobits(real'(i + 1));
      memC[i + 16] = $realtobits(real'(i + 101));
    end
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) memB[y * 5 + x] = $realtobits(real'(10 * y + x));
    #1;
    checkResetState("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] ramp 4x4, start re-pulsed while busy");
    wrLog.delete();
    expectRamp();
    applyStimulus(0, 1'b1, lat);
    checkOutput("ramp latency", 64'(lat), 64'd36);
    verifyLog("ramp", 4);
    checkOutput("ramp busy in done", 64'(busyA), 64'd0);

    $display("[TB] restart from DONE");
    wrLog.delete();
    applyStimulus(0, 1'b0, lat);
    checkOutput("restart valid drop", 64'(validAfterStart), 64'd0);
    checkOutput("restart latency", 64'(lat), 64'd36);
    verifyLog("restart", 4);

    $display("[TB] reset after second write");
    wrLog.delete();
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    n = 0;
    while ((wrLog.size() < 2) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort reached 2 writes", 64'(wrLog.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    checkResetState("abort");
    repeat (4) @(negedge clk);
    checkOutput("abort no more writes", 64'(wrLog.size()), 64'd2);
    rst_n = 1'b1;
    wrLog.delete();
    applyStimulus(0, 1'b0, lat);
    checkOutput("post-abort latency", 64'(lat), 64'd36);
    verifyLog("post-abort", 4);

    $display("[TB] signed windows");
    memA[0]  = $realtobits(-3.0);  memA[1]  = $realtobits(-0.5);
    memA[4]  = $realtobits(-7.0);  memA[5]  = $realtobits(-1.0);
    memA[2]  = $realtobits(-2.0);  memA[3]  = 64'h0;
    memA[6]  = 64'h8000000000000000; memA[7] = $realtobits(-1.0);
    memA[8]  = $realtobits(2.5);   memA[9]  = $realtobits(-9.0);
    memA[12] = $realtobits(2.25);  memA[13] = $realtobits(1e300);
    memA[10] = 64'h8000000000000000; memA[11] = $realtobits(-5.0);
    memA[14] = 64'h8000000000000000; memA[15] = $realtobits(-1.0);
    setExp(0, 0, 0, 0, $realtobits(-0.5));
    setExp(1, 0, 0, 1, 64'h0);
    setExp(2, 0, 1, 0, $realtobits(1e300));
    setExp(3, 0, 1, 1, 64'h8000000000000000);
    wrLog.delete();
    applyStimulus(0, 1'b0, lat);
    verifyLog("signed", 4);

    $display("[TB] 5x5 input, trailing row/col unused");
    setExp(0, 0, 0, 0, $realtobits(11.0));
    setExp(1, 0, 0, 1, $realtobits(13.0));
    setExp(2, 0, 1, 0, $realtobits(31.0));
    setExp(3, 0, 1, 1, $realtobits(33.0));
    wrLog.delete();
    applyStimulus(1, 1'b0, lat);
    checkOutput("odd latency", 64'(lat), 64'd36);
    verifyLog("odd", 4);
    checkOutput("odd out-of-window reads", 64'(oobB), 64'd0);

    $display("[TB] two channels");
    expectRamp();
    setExp(4, 1, 0, 0, $realtobits(106.0));
    setExp(5, 1, 0, 1, $realtobits(108.0));
    setExp(6, 1, 1, 0, $realtobits(114.0));
    setExp(7, 1, 1, 1, $realtobits(116.0));
    wrLog.delete();
    applyStimulus(2, 1'b0, lat);
    checkOutput("twoch latency", 64'(lat), 64'd72);
    verifyLog("twoch", 8);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
